// File: rtl/ram_b_stream_dma_if.sv
// Job control, RAM port B and both byte streams of the port-B DMA engine.
// The master modport is the DMA side; slave is the environment side.
interface ram_b_stream_dma_if #(
  parameter int ram_addr_width = 19,
  parameter int len_width      = 20
);
  logic                      start;
  logic                      dir;
  logic [ram_addr_width-1:0] base_addr;
  logic [len_width-1:0]      len;
  logic                      busy;
  logic                      done;
  logic                      ram_b_en;
  logic                      ram_b_we;
  logic [ram_addr_width-1:0] ram_b_addr;
  logic [7:0]                ram_b_wdata;
  logic [7:0]                ram_b_rdata;
  logic [7:0]                m_tdata;
  logic                      m_tvalid;
  logic                      m_tready;
  logic                      m_tlast;
  logic [7:0]                s_tdata;
  logic                      s_tvalid;
  logic                      s_tready;

  modport master (
    input  start, dir, base_addr, len, ram_b_rdata, m_tready, s_tdata, s_tvalid,
    output busy, done, ram_b_en, ram_b_we, ram_b_addr, ram_b_wdata,
           m_tdata, m_tvalid, m_tlast, s_tready
  );

  modport slave (
    output start, dir, base_addr, len, ram_b_rdata, m_tready, s_tdata, s_tvalid,
    input  busy, done, ram_b_en, ram_b_we, ram_b_addr, ram_b_wdata,
           m_tdata, m_tvalid, m_tlast, s_tready
  );
endinterface

// File: rtl/ram_b_stream_dma.sv
// Byte-stream DMA on RAM port B: RAM-to-stream reads through a 2-entry
// FIFO, or stream-to-RAM writes issued in the same cycle as each beat.
module ram_b_stream_dma #(
  parameter int ram_addr_width = 19,
  parameter int len_width      = 20
) (
  input logic               clk,
  input logic               rst,
  ram_b_stream_dma_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [len_width-1:0]      zero_len  = {len_width{1'b0}};
  localparam logic [len_width-1:0]      one_len   = {{(len_width-1){1'b0}}, 1'b1};
  localparam logic [ram_addr_width-1:0] zero_addr = {ram_addr_width{1'b0}};

  state_t                    state_r;
  state_t                    state_s;
  logic [ram_addr_width-1:0] base_r;
  logic [len_width-1:0]      len_r;
  logic [len_width-1:0]      issued_r;
  logic [len_width-1:0]      popped_r;
  logic                      inflight_r;
  logic [7:0]                fifo_r [0:1];
  logic                      wr_ptr_r;
  logic                      rd_ptr_r;
  logic [1:0]                count_r;

  logic [ram_addr_width-1:0] addr_s;
  logic [2:0]                occ_s;
  logic                      pop_s;
  logic                      issue_s;
  logic                      beat_s;
  logic                      head_last_s;
  logic                      len_zero_s;

  // Handshake qualifiers; occupancy counts FIFO entries plus the read in flight.
  always_comb begin
    len_zero_s  = (len_r == zero_len);
    addr_s      = base_r + ram_addr_width'(issued_r);
    pop_s       = (count_r != 2'd0) && bus.m_tready;
    occ_s       = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s     = (state_r == RD) && (issued_r < len_r) && (occ_s < 3'd2);
    beat_s      = (state_r == WR) && !len_zero_s && bus.s_tvalid;
    head_last_s = (count_r != 2'd0) && (popped_r == (len_r - one_len));
  end

  assign bus.busy        = (state_r == RD) || (state_r == WR);
  assign bus.done        = (state_r == FIN);
  assign bus.ram_b_en    = issue_s || beat_s;
  assign bus.ram_b_we    = beat_s;
  assign bus.ram_b_addr  = (issue_s || beat_s) ? addr_s : zero_addr;
  assign bus.ram_b_wdata = beat_s ? bus.s_tdata : 8'd0;
  assign bus.m_tvalid    = (count_r != 2'd0);
  assign bus.m_tdata     = (count_r != 2'd0) ? fifo_r[rd_ptr_r] : 8'd0;
  assign bus.m_tlast     = head_last_s;
  // A zero-length write job must not accept a beat.
  assign bus.s_tready    = (state_r == WR) && !len_zero_s;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = bus.dir ? WR : RD;
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (len_zero_s || (pop_s && head_last_s)) begin
          state_s = FIN;
        end else begin
          state_s = RD;
        end
      end
      WR: begin
        if (len_zero_s || (beat_s && (issued_r == (len_r - one_len)))) begin
          state_s = FIN;
        end else begin
          state_s = WR;
        end
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, job latch and transfer counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      base_r     <= zero_addr;
      len_r      <= zero_len;
      issued_r   <= zero_len;
      popped_r   <= zero_len;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= issue_s;
      if ((state_r == IDLE) && bus.start) begin
        base_r   <= bus.base_addr;
        len_r    <= bus.len;
        issued_r <= zero_len;
        popped_r <= zero_len;
      end else begin
        if (issue_s || beat_s) begin
          issued_r <= issued_r + one_len;
        end
        if (pop_s) begin
          popped_r <= popped_r + one_len;
        end
      end
    end
  end

  // Two-entry read FIFO; the byte lands one cycle after its issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_r[0] <= 8'd0;
      fifo_r[1] <= 8'd0;
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      count_r   <= 2'd0;
    end else begin
      if (inflight_r) begin
        fifo_r[wr_ptr_r] <= bus.ram_b_rdata;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_ram_b_stream_dma.sv
// Directed bench for ram_b_stream_dma with a behavioural port-B RAM model.
module tb_ram_b_stream_dma;
  localparam int AW = 19;
  localparam int LW = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_b_stream_dma_if #(.ram_addr_width(AW), .len_width(LW)) bus ();
  ram_b_stream_dma #(.ram_addr_width(AW), .len_width(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdata_q;
  always @(posedge clk) begin
    if (bus.ram_b_en) begin
      if (bus.ram_b_we) mem[bus.ram_b_addr] <= bus.ram_b_wdata;
      else              rdata_q <= mem[bus.ram_b_addr];
    end
  end
  assign bus.ram_b_rdata = rdata_q;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle; returns at the next falling edge with start low.
  task automatic kick(input logic d, input logic [AW-1:0] b, input logic [LW-1:0] l);
    @(negedge clk);
    bus.start = 1'b1; bus.dir = d; bus.base_addr = b; bus.len = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [8:0]  wv [0:5];
  logic [18:0] wa [0:3];
  logic [7:0]  wd [0:3];

  initial begin
    int  exp_idx, iss, pops, j;
    bit  got_done, stall_prev, held_last;
    logic [7:0] held;

    rst = 1'b1;
    bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.len = '0;
    bus.m_tready = 1'b0; bus.s_tvalid = 1'b0; bus.s_tdata = 8'h00;
    for (int i = 0; i < 4; i++) mem[19'h10 + i] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) mem[19'h40 + i] = 8'hB0 + 8'(i);
    for (int i = 0; i < 8; i++) mem[19'h80 + i] = 8'hC0 + 8'(i);
    mem[19'h20]  = 8'h5A;
    mem[19'h100] = 8'hD1;
    mem[19'h200] = 8'hE0;
    mem[19'h201] = 8'hE1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_busy", bus.busy, 0); chk("rst_done", bus.done, 0);
    chk("rst_en", bus.ram_b_en, 0); chk("rst_we", bus.ram_b_we, 0);
    chk("rst_tvalid", bus.m_tvalid, 0); chk("rst_tlast", bus.m_tlast, 0);
    chk("rst_sready", bus.s_tready, 0); chk("rst_addr", bus.ram_b_addr, 0);
    @(negedge clk); rst = 1'b0;

    // Read 4 bytes at 0x10 with m_tready held high
    bus.m_tready = 1'b1;
    kick(1'b0, 19'h00010, 20'd4); #1;
    chk("t1_busy", bus.busy, 1); chk("t1_en", bus.ram_b_en, 1);
    chk("t1_we", bus.ram_b_we, 0); chk("t1_addr", bus.ram_b_addr, 32'h10);
    @(negedge clk); #1;
    chk("t1_latency", bus.m_tvalid, 0); chk("t1_addr2", bus.ram_b_addr, 32'h11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t1_valid", bus.m_tvalid, 1);
      chk("t1_data", bus.m_tdata, 32'hA0 + i);
      chk("t1_last", bus.m_tlast, (i == 3) ? 1 : 0);
      chk("t1_no_done", bus.done, 0);
    end
    @(negedge clk); #1;
    chk("t1_done", bus.done, 1); chk("t1_fin_busy", bus.busy, 0);
    chk("t1_fin_valid", bus.m_tvalid, 0);
    @(negedge clk); #1;
    chk("t1_done_once", bus.done, 0);

    // Read 6 bytes at 0x40 with m_tready toggling 1,0,0,1
    kick(1'b0, 19'h00040, 20'd6);
    exp_idx = 0; iss = 0; pops = 0; got_done = 0; stall_prev = 0; held = 8'h00; held_last = 0;
    for (int k = 0; k < 60 && !got_done; k++) begin
      if (k > 0) @(negedge clk);
      bus.m_tready = ((k % 4) == 0) || ((k % 4) == 3);
      #1;
      if (bus.done) begin
        got_done = 1;
      end else begin
        if (stall_prev)
          chk("t2_hold", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, held_last, held});
        if (bus.ram_b_en && !bus.ram_b_we) iss++;
        if (bus.m_tvalid && bus.m_tready) begin
          chk("t2_data", bus.m_tdata, 32'hB0 + exp_idx);
          chk("t2_last", bus.m_tlast, (exp_idx == 5) ? 1 : 0);
          exp_idx++; pops++;
        end
        stall_prev = bus.m_tvalid && !bus.m_tready;
        held = bus.m_tdata; held_last = bus.m_tlast;
        chk("t2_outstanding", ((iss - pops) <= 2) ? 1 : 0, 1);
      end
    end
    chk("t2_done_seen", got_done, 1);
    chk("t2_bytes", exp_idx, 6);
    chk("t2_reads", iss, 6);
    bus.m_tready = 1'b1;

    // Write 4 bytes at 0x7FFFE with gaps, wrapping to 0
    wv = '{9'h111, 9'h000, 9'h122, 9'h133, 9'h000, 9'h144};
    wa = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};
    kick(1'b1, 19'h7FFFE, 20'd4);
    j = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      bus.s_tvalid = wv[i][8]; bus.s_tdata = wv[i][7:0];
      #1;
      chk("t3_sready", bus.s_tready, 1);
      chk("t3_en", bus.ram_b_en, wv[i][8]);
      if (wv[i][8]) begin
        chk("t3_we", bus.ram_b_we, 1);
        chk("t3_addr", bus.ram_b_addr, wa[j]);
        chk("t3_wdata", bus.ram_b_wdata, wd[j]);
        j++;
      end
    end
    @(negedge clk);
    bus.s_tvalid = 1'b1; bus.s_tdata = 8'h55;
    #1;
    chk("t3_done", bus.done, 1); chk("t3_sready_fin", bus.s_tready, 0);
    chk("t3_en_fin", bus.ram_b_en, 0);
    @(negedge clk); bus.s_tvalid = 1'b0; #1;
    chk("t3_mem_7fffe", mem[19'h7FFFE], 32'h11);
    chk("t3_mem_7ffff", mem[19'h7FFFF], 32'h22);
    chk("t3_mem_0", mem[19'h00000], 32'h33);
    chk("t3_mem_1", mem[19'h00001], 32'h44);

    // Zero-length read, with start pulses while busy and in FIN
    kick(1'b0, 19'h00300, 20'd0);
    bus.start = 1'b1; bus.dir = 1'b1; bus.len = 20'd5; #1;
    chk("t4r_busy", bus.busy, 1); chk("t4r_en", bus.ram_b_en, 0);
    chk("t4r_valid", bus.m_tvalid, 0); chk("t4r_nodone", bus.done, 0);
    @(negedge clk); #1;
    chk("t4r_done", bus.done, 1); chk("t4r_en_fin", bus.ram_b_en, 0);
    @(negedge clk); bus.start = 1'b0; #1;
    chk("t4r_done_once", bus.done, 0); chk("t4r_idle", bus.busy, 0);
    @(negedge clk); #1;
    chk("t4r_start_ignored", bus.busy, 0);

    // Zero-length write: no beat accepted even with s_tvalid high
    kick(1'b1, 19'h00300, 20'd0);
    bus.s_tvalid = 1'b1; bus.s_tdata = 8'h99; #1;
    chk("t4w_busy", bus.busy, 1); chk("t4w_sready", bus.s_tready, 0);
    chk("t4w_en", bus.ram_b_en, 0);
    @(negedge clk); #1;
    chk("t4w_done", bus.done, 1); chk("t4w_en_fin", bus.ram_b_en, 0);
    @(negedge clk); bus.s_tvalid = 1'b0;

    // Reset in the middle of an 8-byte read, then a 1-byte job at 0x20
    kick(1'b0, 19'h00080, 20'd8);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_b0", bus.m_tdata, 32'hC0);
    @(negedge clk); #1;
    chk("t5_b1", bus.m_tdata, 32'hC1);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("t5_busy", bus.busy, 0); chk("t5_en", bus.ram_b_en, 0);
    chk("t5_valid", bus.m_tvalid, 0); chk("t5_last", bus.m_tlast, 0);
    chk("t5_done", bus.done, 0); chk("t5_sready", bus.s_tready, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("t5_quiet", {bus.done, bus.busy, bus.m_tvalid, bus.ram_b_en}, 0);
    end
    kick(1'b0, 19'h00020, 20'd1); #1;
    chk("t5n_en", bus.ram_b_en, 1); chk("t5n_addr", bus.ram_b_addr, 32'h20);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5n_data", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, 1'b1, 8'h5A});
    @(negedge clk); #1;
    chk("t5n_done", bus.done, 1);

    // Back-to-back: second start in the cycle after done
    kick(1'b0, 19'h00100, 20'd1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6a_data", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, 1'b1, 8'hD1});
    @(negedge clk); #1;
    chk("t6a_done", bus.done, 1);
    kick(1'b0, 19'h00200, 20'd2); #1;
    chk("t6b_busy", bus.busy, 1); chk("t6b_addr", bus.ram_b_addr, 32'h200);
    chk("t6b_en", bus.ram_b_en, 1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6b_d0", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, 1'b0, 8'hE0});
    @(negedge clk); #1;
    chk("t6b_d1", {bus.m_tvalid, bus.m_tlast, bus.m_tdata}, {1'b1, 1'b1, 8'hE1});
    @(negedge clk); #1;
    chk("t6b_done", bus.done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
